nios2_system_mm_copy_master: RTL and testbench
==============================================

// Module: nios2_system_mm_copy_master
// PURPOSE
//  Avalon-MM master that copies a block of 32-bit words from one address range to another.
//  It drives the same read/write slave interface the on-chip memory presents (s1/s2).
//  Sits beside the Nios II on the system interconnect and offloads memory fills, copies and
//  buffer moves within on-chip RAM.
//  One outstanding transfer at a time; tolerant of any waitrequest stall and any read latency >= 1.
// PARAMETERS
//  ADDR_W   32   byte-address width of avm_address and the src/dst inputs
//  LEN_W    16   width of the word-count input and counters
// PORTS
//  clk                 in   1       system clock; all logic on rising edge
//  reset_n             in   1       asynchronous active-low reset
//  start               in   1       one-cycle request; sampled only in IDLE
//  src_addr            in   ADDR_W  source byte address; bits[1:0] ignored (forced 0)
//  dst_addr            in   ADDR_W  destination byte address; bits[1:0] ignored (forced 0)
//  len_words           in   LEN_W   number of 32-bit words to copy
//  busy                out  1       high from the cycle after an accepted start until DONE
//  done                out  1       one-cycle pulse when the copy completes
//  words_done          out  LEN_W   words written so far in the current or last copy
//  avm_address         out  ADDR_W  master byte address, word aligned
//  avm_read            out  1       read request
//  avm_write           out  1       write request
//  avm_byteenable      out  4       always 4'hF while avm_write=1; 4'hF otherwise
//  avm_writedata       out  32      write data
//  avm_waitrequest     in   1       slave stall; request held while high
//  avm_readdata        in   32      read data
//  avm_readdatavalid   in   1       qualifies avm_readdata
// BEHAVIOUR
//  Reset (reset_n low, async): state=IDLE; busy=0, done=0, words_done=0, avm_read=0,
//   avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=4'hF. Reset mid-copy
//   abandons the transfer immediately; no done pulse is generated.
//  FSM: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> (RD_REQ | DONE) -> IDLE.
//  IDLE: start=1 latches src_ptr={src_addr[ADDR_W-1:2],2'b00}, dst_ptr likewise, and
//   remaining=len_words; clears words_done. If len_words==0 -> DONE, else -> RD_REQ.
//   start in any state other than IDLE is ignored.
//  RD_REQ: avm_read=1, avm_address=src_ptr. Held stable while avm_waitrequest=1.
//   The read is accepted in the cycle avm_waitrequest=0 -> RD_WAIT (read drops the next cycle).
//  RD_WAIT: avm_read=0. Wait for avm_readdatavalid=1, then capture avm_readdata -> WR_REQ.
//   readdatavalid outside RD_WAIT is ignored (earliest legal return: 1 cycle after acceptance).
//  WR_REQ: avm_write=1, avm_address=dst_ptr, avm_writedata=captured word, byteenable=4'hF;
//   held stable while waitrequest=1. On acceptance: src_ptr+=4, dst_ptr+=4,
//   words_done+=1, remaining-=1. If remaining was 1 -> DONE, else -> RD_REQ.
//  avm_read and avm_write are never high in the same cycle.
//  Minimum cost is 3 cycles per word (RD_REQ, RD_WAIT, WR_REQ) with zero wait and latency 1.
//  DONE: done=1 for exactly one cycle, busy=0 -> IDLE. A start in the cycle after DONE is accepted.
//  busy=1 in RD_REQ, RD_WAIT and WR_REQ only.
//  Pointers wrap modulo 2^ADDR_W; no bounds check.
//  Overlapping ranges are copied strictly forward, word by word; no hazard correction.
//  words_done holds its final value until the next accepted start.
// TESTING
//  1. Slave model is 8192x32 RAM with zero wait and latency 1. Preload src 0x0000..0x003C with i.
//     Start src=0x0, dst=0x100, len=16 -> dst words 0x100..0x13C hold 0..15.
//     done pulses once, 48 cycles after start; words_done=16.
//  2. len=0 -> done pulses the cycle after start; no avm_read/avm_write is ever asserted.
//  3. Random waitrequest (50%) and readdatavalid latency 1..4, len=64 -> data matches.
//     Address, read, write and writedata stay stable throughout every stall.
//  4. src=0x13 and dst=0x22 -> accesses hit 0x10 and 0x20; addresses step by 4.
//  5. Assert reset_n low during WR_REQ of word 5 of 10 -> all outputs return to reset
//     values in the same cycle; no done; a new start then runs normally.
//  6. Re-issue start while busy -> ignored; source src=0xFFFFFFF8 with len=4 wraps to 0x0, 0x4.

Source files
------------

// File: rtl/nios2_system_mm_copy_master.sv
// Avalon-MM copy engine: moves a block of 32-bit words from src to dst, one
// read then one write per word, with a single transfer outstanding at a time.
module nios2_system_mm_copy_master #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  wdone_q, wdone_d;
    logic [31:0]       data_q, data_d;

    // The low two address bits are dropped by design; keep them visibly consumed.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            wdone_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            wdone_q <= wdone_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wdone_d = wdone_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = {src_addr[ADDR_W-1:2], 2'b00};
                    dst_d   = {dst_addr[ADDR_W-1:2], 2'b00};
                    rem_d   = len_words;
                    wdone_d = '0;
                    state_d = (len_words == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    data_d  = avm_readdata;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (!avm_waitrequest) begin
                    src_d   = src_q + ADDR_W'(4);
                    dst_d   = dst_q + ADDR_W'(4);
                    rem_d   = rem_q - LEN_W'(1);
                    wdone_d = wdone_q + LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from registered state only, so they cannot
    // change during a waitrequest stall and drop to idle values as soon as reset hits.
    always_comb begin
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        case (state_q)
            S_RD_REQ: begin
                avm_read    = 1'b1;
                avm_address = src_q;
            end
            S_WR_REQ: begin
                avm_write     = 1'b1;
                avm_address   = dst_q;
                avm_writedata = data_q;
            end
            default: begin
                avm_read = 1'b0;
            end
        endcase
    end

    assign avm_byteenable = 4'hF;
    assign busy           = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) || (state_q == S_WR_REQ);
    assign done           = (state_q == S_DONE);
    assign words_done     = wdone_q;

endmodule

// File: tb/tb_nios2_system_mm_copy_master.sv
// Bench for the copy master: RAM slave model with optional random stalls and
// read latency, plus a scoreboard of expected read addresses and write beats.
module tb_nios2_system_mm_copy_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic [15:0] words_done;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    always #5 clk = ~clk;

    nios2_system_mm_copy_master #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .len_words         (len_words),
        .busy              (busy),
        .done              (done),
        .words_done        (words_done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    logic [31:0] mem [0:8191];
    logic [31:0] rd_q [$];
    logic [63:0] wr_q [$];
    int          checks = 0;
    int          failures = 0;
    bit          stress = 1'b0;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          lat_cnt = 0;
    logic [31:0] rd_data_pend;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_wd;
    logic        prev_rd, prev_wr;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Slave: drives stall/return at posedge+1, evaluates the cycle's request at negedge.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) lat_cnt = 0;
            avm_readdatavalid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = rd_data_pend;
                end
            end
            avm_waitrequest = stress ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (done) done_cnt++;
            if (avm_read && avm_write) chk("rd_wr_exclusive", {avm_read, avm_write}, 2'b10);
            if (prev_stall && reset_n) begin
                chk("stall_addr", avm_address, prev_addr);
                chk("stall_read", avm_read, prev_rd);
                chk("stall_write", avm_write, prev_wr);
                chk("stall_wdata", avm_writedata, prev_wd);
            end
            prev_stall = (avm_read || avm_write) && avm_waitrequest && reset_n;
            prev_addr  = avm_address;
            prev_rd    = avm_read;
            prev_wr    = avm_write;
            prev_wd    = avm_writedata;
            if (avm_read && !avm_waitrequest) begin
                rd_cnt++;
                if (rd_q.size() == 0) chk("rd_unexpected", rd_q.size(), 1);
                else chk("rd_addr", avm_address, rd_q.pop_front());
                rd_data_pend = mem[avm_address[14:2]];
                lat_cnt      = stress ? int'($urandom_range(1, 4)) : 1;
            end
            if (avm_write && !avm_waitrequest) begin
                logic [63:0] e;
                wr_cnt++;
                chk("wr_byteenable", avm_byteenable, 4'hF);
                if (wr_q.size() == 0) chk("wr_unexpected", wr_q.size(), 1);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", avm_address, e[63:32]);
                    chk("wr_data", avm_writedata, e[31:0]);
                end
                mem[avm_address[14:2]] = avm_writedata;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_words_done"}, words_done, 16'd0);
        chk({tag, "_read"}, avm_read, 1'b0);
        chk({tag, "_write"}, avm_write, 1'b0);
        chk({tag, "_address"}, avm_address, 32'd0);
        chk({tag, "_writedata"}, avm_writedata, 32'd0);
        chk({tag, "_byteenable"}, avm_byteenable, 4'hF);
    endtask

    // Pushes the expected traffic, then drives a one-cycle start.
    task automatic begin_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        logic [31:0] a, w;
        for (int i = 0; i < int'(n); i++) begin
            a = (s & 32'hFFFF_FFFC) + 32'(4 * i);
            w = (d & 32'hFFFF_FFFC) + 32'(4 * i);
            rd_q.push_back(a);
            wr_q.push_back({w, mem[a[14:2]]});
        end
        start     = 1'b1;
        src_addr  = s;
        dst_addr  = d;
        len_words = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        $display("copy start src=0x%08h dst=0x%08h len=%0d", s, d, n);
    endtask

    task automatic wait_done(input logic [15:0] n, input int exp_cycles);
        int cyc = 0;
        int dc0 = done_cnt;
        while (!done && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_seen", done, 1'b1);
        if (exp_cycles >= 0) chk("done_latency", cyc, exp_cycles);
        chk("words_done_final", words_done, n);
        chk("busy_in_done", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("done_single_cycle", done, 1'b0);
        chk("done_pulse_count", done_cnt - dc0, 1);
        chk("words_done_hold", words_done, n);
        chk("sb_reads_left", rd_q.size(), 0);
        chk("sb_writes_left", wr_q.size(), 0);
        $display("copy done len=%0d cycles=%0d words_done=%0d", n, cyc, words_done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, wc, dc;
        reset_n   = 1'b0;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len_words = '0;
        for (int i = 0; i < 8192; i++) mem[i] = (i < 16) ? 32'(i) : (32'(i) ^ 32'h5A5A_0000);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: zero-wait copy of 0..15 to 0x100
        begin_copy(32'h0, 32'h100, 16'd16);
        chk("busy_after_start", busy, 1'b1);
        wait_done(16'd16, 48);
        for (int i = 0; i < 16; i++) chk("dst_content", mem[32'h40 + i], 32'(i));

        // 2: zero-length copy
        rc = rd_cnt;
        wc = wr_cnt;
        begin_copy(32'h40, 32'h300, 16'd0);
        wait_done(16'd0, 0);
        chk("len0_reads", rd_cnt - rc, 0);
        chk("len0_writes", wr_cnt - wc, 0);

        // 3: random stalls and latency
        for (int i = 0; i < 64; i++) mem[32'h80 + i] = $urandom;
        stress = 1'b1;
        begin_copy(32'h200, 32'h800, 16'd64);
        wait_done(16'd64, -1);
        stress = 1'b0;

        // 4: unaligned addresses are forced to word boundaries
        begin_copy(32'h13, 32'h22, 16'd4);
        chk("unaligned_first_rd", avm_address, 32'h10);
        wait_done(16'd4, 12);

        // 5: reset during the write of word 5 of 10
        begin_copy(32'h400, 32'hC00, 16'd10);
        for (int k = 0; k < 200; k++) begin
            if (avm_write && words_done == 16'd4) break;
            @(posedge clk);
            #1;
        end
        chk("reached_word5_write", {avm_write, words_done}, {1'b1, 16'd4});
        dc = done_cnt;
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midcopy_reset");
        rd_q.delete();
        wr_q.delete();
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("no_done_after_reset", done_cnt - dc, 0);
        chk("idle_after_reset", busy, 1'b0);
        begin_copy(32'h400, 32'hC00, 16'd10);
        wait_done(16'd10, 30);

        // 6: start while busy is ignored; source wraps past the top of the address space
        begin_copy(32'h600, 32'hE00, 16'd8);
        repeat (4) @(posedge clk);
        #1;
        start     = 1'b1;
        src_addr  = 32'h700;
        dst_addr  = 32'hF00;
        len_words = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(16'd8, -1);
        mem[13'h1FFE] = 32'hCAFE_0001;
        mem[13'h1FFF] = 32'hCAFE_0002;
        begin_copy(32'hFFFF_FFF8, 32'h1000, 16'd4);
        chk("wrap_first_rd", avm_address, 32'hFFFF_FFF8);
        wait_done(16'd4, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
